osd_llr_frame_loader: RTL and testbench

//  Upstream stage of the OSD-2 decoder core. Accepts one quantized channel LLR per cycle over a valid/ready

---
 rtl/osd_pkg.sv | 36 +++
 rtl/osd_llr_sat.sv | 26 ++
 rtl/osd_llr_frame_loader.sv | 150 +++++++++++++++
 tb/tb_osd_llr_frame_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared OSD decoder defaults, LLR clamp limits and the frame loader state type.
package osd_pkg;

  localparam int N         = 64;
  localparam int BIT_WIDTH = 6;
  localparam int IN_WIDTH  = 8;
  localparam int IDX_W     = $clog2(N);

  localparam logic signed [BIT_WIDTH-1:0] LLR_MAX = BIT_WIDTH'((1 << (BIT_WIDTH-1)) - 1);
  localparam logic signed [BIT_WIDTH-1:0] LLR_MIN = BIT_WIDTH'(-(1 << (BIT_WIDTH-1)));

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } ldr_state_e;

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] val;
    logic                        sat;
  } llr_sat_t;

  function automatic llr_sat_t llr_sat(input logic signed [IN_WIDTH-1:0] in);
    llr_sat_t r;
    r.val = in[BIT_WIDTH-1:0];
    r.sat = 1'b0;
    if (in > IN_WIDTH'(LLR_MAX)) begin
      r.val = LLR_MAX;
      r.sat = 1'b1;
    end else if (in < IN_WIDTH'(LLR_MIN)) begin
      r.val = LLR_MIN;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/osd_llr_sat.sv
// Combinational LLR clamp from IN_WIDTH to BIT_WIDTH with a saturation flag.
module osd_llr_sat #(
  parameter int IN_WIDTH  = osd_pkg::IN_WIDTH,
  parameter int BIT_WIDTH = osd_pkg::BIT_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0]  llr_i,
  output logic signed [BIT_WIDTH-1:0] llr_o,
  output logic                        sat_o
);

  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'((1 << (BIT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] LO = IN_WIDTH'(-(1 << (BIT_WIDTH-1)));

  always_comb begin
    llr_o = llr_i[BIT_WIDTH-1:0];
    sat_o = 1'b0;
    if (llr_i > HI) begin
      llr_o = HI[BIT_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (llr_i < LO) begin
      llr_o = LO[BIT_WIDTH-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/osd_llr_frame_loader.sv
// Streams saturated LLRs into an N-sample fill buffer and issues whole frames to the OSD core.
// Optional per-frame saturation counter: define OSD_LOADER_SAT_CNT_EN.
module osd_llr_frame_loader #(
  parameter int N         = osd_pkg::N,
  parameter int BIT_WIDTH = osd_pkg::BIT_WIDTH,
  parameter int IN_WIDTH  = osd_pkg::IN_WIDTH,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] in_llr,
  input  logic                       in_last,
  input  logic                       dec_busy,
  output logic [N*BIT_WIDTH-1:0]     y,
  output logic                       y_valid,
  output logic                       frame_err,
  output logic [IDX_W:0]             sat_count
);

  import osd_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ldr_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic signed [BIT_WIDTH-1:0] fill_q [N];
  logic [N*BIT_WIDTH-1:0]      y_q;
  logic                        y_valid_q, y_valid_d;
  logic                        frame_err_q, frame_err_d;
  logic                        accept, last_slot, issue;
  logic signed [BIT_WIDTH-1:0] sat_val;
  logic                        sat_flag;

  osd_llr_sat #(
    .IN_WIDTH (IN_WIDTH),
    .BIT_WIDTH(BIT_WIDTH)
  ) u_sat (
    .llr_i(in_llr),
    .llr_o(sat_val),
    .sat_o(sat_flag)
  );

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign last_slot = (wr_ptr_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    y_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    issue       = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last && last_slot) begin
            state_d  = FULL;
            wr_ptr_d = '0;
          end else if (in_last || last_slot) begin
            // Short or overlong frame: drop what was collected and restart.
            frame_err_d = 1'b1;
            wr_ptr_d    = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (!dec_busy && !y_valid_q) begin
          issue     = 1'b1;
          y_valid_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      y_valid_q   <= y_valid_d;
      frame_err_q <= frame_err_d;
      if (issue) begin
        for (int i = 0; i < N; i++) begin
          y_q[i*BIT_WIDTH +: BIT_WIDTH] <= fill_q[i];
        end
      end
    end
  end

  // Fill buffer is pure data; a reset simply abandons its contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      fill_q[wr_ptr_q] <= sat_val;
    end
  end

`ifdef OSD_LOADER_SAT_CNT_EN
  localparam logic [IDX_W:0] CNT_MAX = '1;

  logic [IDX_W:0] sat_cnt_q, sat_cnt_d;
  logic [IDX_W:0] sat_count_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (frame_err_d) begin
      sat_cnt_d = '0;
    end else if (accept) begin
      if (wr_ptr_q == '0) begin
        sat_cnt_d = {{IDX_W{1'b0}}, sat_flag};
      end else if (sat_flag && (sat_cnt_q != CNT_MAX)) begin
        sat_cnt_d = sat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q   <= '0;
      sat_count_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (issue) begin
        sat_count_q <= sat_cnt_q;
      end
    end
  end

  assign sat_count = sat_count_q;
`else
  logic sat_unused;
  assign sat_unused = sat_flag;
  assign sat_count  = '0;
`endif

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_osd_llr_frame_loader.sv
// Directed bench for osd_llr_frame_loader: clamp table, framing, backpressure and reset cases.
module tb_osd_llr_frame_loader;

  localparam int N     = 64;
  localparam int BW    = 6;
  localparam int IW    = 8;
  localparam int IDX_W = 6;

`ifdef OSD_LOADER_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_llr;
  logic                 in_last;
  logic                 dec_busy;
  logic [N*BW-1:0]      y;
  logic                 y_valid;
  logic                 frame_err;
  logic [IDX_W:0]       sat_count;

  always #5 clk = ~clk;

  osd_llr_frame_loader #(
    .N(N), .BIT_WIDTH(BW), .IN_WIDTH(IW), .IDX_W(IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_llr   (in_llr),
    .in_last  (in_last),
    .dec_busy (dec_busy),
    .y        (y),
    .y_valid  (y_valid),
    .frame_err(frame_err),
    .sat_count(sat_count)
  );

  int n_vec = 0;
  int n_err = 0;

  int   yv_pulses = 0;
  int   fe_pulses = 0;
  int   back2back = 0;
  logic yv_prev   = 1'b0;

  always @(negedge clk) begin
    if (y_valid) yv_pulses++;
    if (frame_err) fe_pulses++;
    if (y_valid && yv_prev) back2back++;
    yv_prev = y_valid;
  end

  typedef struct {
    logic signed [IW-1:0] llr;
    logic signed [BW-1:0] exp;
    bit                   sat;
  } clamp_vec_t;

  clamp_vec_t           tbl [12];
  logic signed [IW-1:0] stim [N];
  logic signed [BW-1:0] expv [N];
  int                   exp_sat;
  logic [N*BW-1:0]      y_hold;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int cnt, input int last_at);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_llr   = stim[i];
      in_last  = (i == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_table();
    exp_sat = 0;
    for (int i = 0; i < N; i++) begin
      if (i < 12) begin
        stim[i] = tbl[i].llr;
        expv[i] = tbl[i].exp;
        if (tbl[i].sat) exp_sat++;
      end else begin
        stim[i] = 8'sd7;
        expv[i] = 6'sd7;
      end
    end
  endtask

  task automatic run_frame(input string nm, input int busy);
    dec_busy = (busy > 0);
    y_hold   = y;
    send(N, N - 1);
    chk({nm, " full in_ready"}, in_ready, 0);
    chk({nm, " full y_valid"}, y_valid, 0);
    for (int k = 0; k < busy; k++) begin
      tick();
      chk($sformatf("%s busy%0d rdy/vld", nm, k), {in_ready, y_valid}, 0);
      chk($sformatf("%s busy%0d y held", nm, k), (y === y_hold), 1);
    end
    dec_busy = 1'b0;
    tick();
    chk({nm, " issue y_valid"}, y_valid, 1);
    chk({nm, " issue in_ready"}, in_ready, 1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s y[%0d]", nm, i), $signed(y[i*BW +: BW]), expv[i]);
    end
    chk({nm, " sat_count"}, sat_count, SAT_EN ? exp_sat : 0);
    tick();
    chk({nm, " y_valid drop"}, y_valid, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_llr   = '0;
    in_last  = 1'b0;
    dec_busy = 1'b0;

    tbl[0]  = '{8'(-128), 6'(-32), 1'b1};
    tbl[1]  = '{8'(127),  6'(31),  1'b1};
    tbl[2]  = '{8'(31),   6'(31),  1'b0};
    tbl[3]  = '{8'(32),   6'(31),  1'b1};
    tbl[4]  = '{8'(-32),  6'(-32), 1'b0};
    tbl[5]  = '{8'(-33),  6'(-32), 1'b1};
    tbl[6]  = '{8'(0),    6'(0),   1'b0};
    tbl[7]  = '{8'(1),    6'(1),   1'b0};
    tbl[8]  = '{8'(-1),   6'(-1),  1'b0};
    tbl[9]  = '{8'(5),    6'(5),   1'b0};
    tbl[10] = '{8'(-17),  6'(-17), 1'b0};
    tbl[11] = '{8'(100),  6'(31),  1'b1};

    // Reset state
    repeat (3) tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst y_valid", y_valid, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst sat_count", sat_count, 0);
    chk("rst y zero", (y === '0), 1);
    rst_n = 1'b1;
    tick();
    chk("post-rst y_valid", y_valid, 0);

    // Clean ramp frame
    for (int i = 0; i < N; i++) begin
      stim[i] = 8'(-(64 - i));
      expv[i] = (i <= 32) ? 6'(-32) : 6'(-(64 - i));
    end
    exp_sat = 32;
    run_frame("clean", 0);

    // Backpressure held by dec_busy
    for (int i = 0; i < N; i++) begin
      stim[i] = 8'(i - 20);
      expv[i] = (i >= 52) ? 6'(31) : 6'(i - 20);
    end
    exp_sat = 12;
    run_frame("bp", 8);

    // Early in_last
    for (int i = 0; i < N; i++) stim[i] = 8'sd9;
    send(11, 10);
    chk("early frame_err", frame_err, 1);
    chk("early in_ready", in_ready, 1);
    tick();
    chk("early frame_err drop", frame_err, 0);
    chk("early no y_valid", yv_pulses, 2);
    load_table();
    run_frame("tbl", 0);

    // Missing in_last
    for (int i = 0; i < N; i++) stim[i] = 8'sd3;
    send(N, -1);
    chk("nolast frame_err", frame_err, 1);
    chk("nolast in_ready", in_ready, 1);
    tick();
    chk("nolast frame_err drop", frame_err, 0);
    chk("nolast y_valid", y_valid, 0);

    // Saturation count frame, also proves wr_ptr returned to 0
    for (int i = 0; i < N; i++) begin
      stim[i] = 8'sd0;
      expv[i] = 6'sd0;
    end
    stim[0] = 8'(127);  expv[0] = 6'(31);
    stim[1] = 8'(-128); expv[1] = 6'(-32);
    stim[2] = 8'(5);    expv[2] = 6'(5);
    exp_sat = 2;
    run_frame("sat", 0);

    // Reset in the middle of a fill
    for (int i = 0; i < N; i++) stim[i] = 8'sd25;
    send(30, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst y_valid", y_valid, 0);
    chk("midrst frame_err", frame_err, 0);
    chk("midrst sat_count", sat_count, 0);
    chk("midrst y zero", (y === '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst release y_valid", y_valid, 0);
    load_table();
    run_frame("post_rst", 0);
    chk("post_rst frame_err count", fe_pulses, 2);

    chk("total y_valid pulses", yv_pulses, 5);
    chk("back-to-back y_valid", back2back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
